sync_fifo: RTL and testbench
============================

# sync_fifo

Synchronous single-clock FIFO: the storage element driven by the FIFO transaction/stimulus environment through `FIFO_if`. Accepts write requests on `data_in`/`wr_en` and serves read requests on `rd_en`/`data_out`. Reports handshake and error status: `wr_ack`, `overflow`, `underflow`. Reports occupancy flags: `full`, `empty`, `almostfull`, `almostempty`.

## Interface
- `FIFO_WIDTH`, default 16: data word width.
- `FIFO_DEPTH`, default 8: number of entries; any value ≥ 2, not required to be a power of two.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `data_in`  in  FIFO_WIDTH  write data.
- `wr_en`  in  1  write request.
- `rd_en`  in  1  read request.
- `data_out`  out  FIFO_WIDTH  registered read data.
- `wr_ack`  out  1  registered; previous-cycle write accepted.
- `overflow`  out  1  registered; previous-cycle write rejected because the FIFO was full.
- `underflow`  out  1  registered; previous-cycle read rejected because the FIFO was empty.
- `full`  out  1  combinational; `count == FIFO_DEPTH`.
- `empty`  out  1  combinational; `count == 0`.
- `almostfull`  out  1  combinational; `count == FIFO_DEPTH-1`.
- `almostempty`  out  1  combinational; `count == 1`.

## Operation
- **State:** `mem[FIFO_DEPTH]`, `wr_ptr`/`rd_ptr` (width `$clog2(FIFO_DEPTH)`), `count` (width `$clog2(FIFO_DEPTH)+1`).
- **Pointer wrap:** pointers wrap explicitly to 0 after `FIFO_DEPTH-1`; no reliance on natural binary rollover.
- **Write accepted** (`wr_en && !full`):
  - `mem[wr_ptr] <= data_in`, `wr_ptr` advances.
  - `wr_ack <= 1`, `overflow <= 0`.
- **Write rejected** (`wr_en && full`):
  - `wr_ack <= 0`, `overflow <= 1`.
  - Memory and `wr_ptr` unchanged.
- **No write** (`!wr_en`): `wr_ack <= 0`, `overflow <= 0`.
- **Read accepted** (`rd_en && !empty`):
  - `data_out <= mem[rd_ptr]`, `rd_ptr` advances.
  - `underflow <= 0`.
- **Read rejected** (`rd_en && empty`): `underflow <= 1`; `data_out` holds.
- **No read** (`!rd_en`): `underflow <= 0`; `data_out` holds.
- **Count update:**
  - +1 on write-only accept.
  - −1 on read-only accept.
  - Unchanged when both are accepted.
- **Simultaneous `wr_en && rd_en`:**
  - When empty: only the write is accepted; `underflow <= 1`; `count` becomes 1.
  - When full: only the read is accepted; `overflow <= 1`; `count` becomes `FIFO_DEPTH-1`.
  - Otherwise: both are accepted.
  - `rd_ptr` always reads a previously written entry; there is no write-through bypass.
- **Flag exclusivity:** `full`/`almostfull` are mutually exclusive, as are `empty`/`almostempty`.
- **`data_in`** is ignored when the write is not accepted.

## Timing
- **Reset** (`rst_n` low, asynchronous): `wr_ptr=rd_ptr=count=0`.
  - `data_out=0`, `wr_ack=0`, `overflow=0`, `underflow=0`.
  - Flags: `empty=1`, `full=0`, `almostfull=0`, `almostempty=0`.
  - Memory contents are not reset.
- **Reset mid-operation:** all queued data is discarded immediately; the first cycle after `rst_n` rises behaves as an empty FIFO.
- **Write latency:** `wr_ack`/`overflow` are valid the cycle after the request edge.
- **Flag timing:** `full`/`almostfull`/`empty`/`almostempty` reflect the new count immediately after the edge.
- **Read latency:** 1 cycle; data sampled on edge N appears on `data_out` after edge N and holds until the next accepted read or reset.
- **First-write visibility:** the earliest a word can be read is the edge after its write edge.
- **Throughput:** one write and one read per cycle sustained when neither full nor empty.

## Configuration
- Macro: `FIFO_SVA_EN`.
- **Defined:** the block compiles in concurrent assertions, all disabled during reset:
  - `full` implies `!empty`.
  - `count <= FIFO_DEPTH`.
  - A rejected write leaves `wr_ptr` stable.
  - A rejected read leaves `rd_ptr` stable.
  - `wr_ack` and `overflow` are never both high.
  - `wr_ptr == rd_ptr` implies `full || empty`.
  - One cover property per flag assertion.
- **Undefined:** no assertion or cover code is compiled; functional behaviour is identical.

## Test plan
All scenarios use `FIFO_WIDTH=16`, `FIFO_DEPTH=8`.
- **Reset:** hold `rst_n=0` for 2 cycles, then release → `empty=1`, all other outputs 0, `data_out=16'h0000`.
- **Fill and overflow:** write `16'h0001`..`16'h0008` on consecutive cycles, then one more write of `16'hDEAD`.
  - `wr_ack=1` for the 8 accepted writes.
  - `almostfull=1` after the 7th write; `full=1` after the 8th.
  - The 9th write gives `overflow=1`, `wr_ack=0`, `count` stays 8.
- **Drain and underflow:** from full, 8 reads followed by one extra read.
  - `data_out` sequence is `0001`..`0008` in order.
  - `almostempty=1` after the 7th read; `empty=1` after the 8th.
  - The extra read gives `underflow=1` and `data_out` holds `0008`.
- **Simultaneous on empty:** `wr_en=rd_en=1`, `data_in=16'hA5A5` → `wr_ack=1`, `underflow=1`, `count=1`, `almostempty=1`; `data_out` unchanged.
- **Simultaneous on full and mid-level:**
  - From full: `wr_en=rd_en=1` → `overflow=1`, the read returns the oldest word, `almostfull=1`.
  - At count=4: 10 cycles of `wr_en=rd_en=1` with incrementing data → count stays 4; output order is preserved across pointer wrap.
- **Async reset mid-stream:** assert `rst_n=0` between clock edges at count=5 → outputs go to reset values without waiting for a clock edge; a subsequent read gives `underflow=1`.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, registered
// write-ack / overflow / underflow status and combinational occupancy flags.
// FIFO_DEPTH may be any value >= 2; pointers wrap explicitly at FIFO_DEPTH-1.
// Optional macro FIFO_SVA_EN compiles in concurrent assertions and covers.
module sync_fifo #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;

   logic                  wr_accept;
   logic                  rd_accept;
   logic [PTR_W-1:0]      wr_ptr_next;
   logic [PTR_W-1:0]      rd_ptr_next;

   // Occupancy flags decoded directly from the current count.
   always_comb begin
      full        = (count == CNT_FULL);
      empty       = (count == '0);
      almostfull  = (count == CNT_AFULL);
      almostempty = (count == CNT_ONE);
   end

   // Accept decisions and wrapped pointer increments.
   // When full, only the read can be accepted; when empty, only the write.
   always_comb begin
      wr_accept   = wr_en && !full;
      rd_accept   = rd_en && !empty;
      wr_ptr_next = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      rd_ptr_next = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
   end

   // Storage array; contents are intentionally left unreset.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Write side: pointer advance and registered write handshake status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         wr_ack   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr   <= wr_ptr_next;
            wr_ack   <= 1'b1;
            overflow <= 1'b0;
         end else if (wr_en) begin
            wr_ack   <= 1'b0;
            overflow <= 1'b1;
         end else begin
            wr_ack   <= 1'b0;
            overflow <= 1'b0;
         end
      end
   end

   // Read side: registered data output, pointer advance and underflow status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr    <= '0;
         data_out  <= '0;
         underflow <= 1'b0;
      end else begin
         if (rd_accept) begin
            data_out  <= mem[rd_ptr];
            rd_ptr    <= rd_ptr_next;
            underflow <= 1'b0;
         end else if (rd_en) begin
            underflow <= 1'b1;
         end else begin
            underflow <= 1'b0;
         end
      end
   end

   // Occupancy counter; a simultaneous accepted read and write cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         case ({wr_accept, rd_accept})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef FIFO_SVA_EN
   a_full_not_empty : assert property (@(posedge clk) disable iff (!rst_n)
      full |-> !empty);

   a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
      count <= CNT_FULL);

   a_wr_reject_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (wr_en && full) |=> $stable(wr_ptr));

   a_rd_reject_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (rd_en && empty) |=> $stable(rd_ptr));

   a_ack_ovf_excl : assert property (@(posedge clk) disable iff (!rst_n)
      !(wr_ack && overflow));

   a_ptr_eq_full_empty : assert property (@(posedge clk) disable iff (!rst_n)
      (wr_ptr == rd_ptr) |-> (full || empty));

   a_full_afull_excl : assert property (@(posedge clk) disable iff (!rst_n)
      !(full && almostfull));

   a_empty_aempty_excl : assert property (@(posedge clk) disable iff (!rst_n)
      !(empty && almostempty));

   c_full        : cover property (@(posedge clk) disable iff (!rst_n) full);
   c_empty       : cover property (@(posedge clk) disable iff (!rst_n) empty);
   c_almostfull  : cover property (@(posedge clk) disable iff (!rst_n) almostfull);
   c_almostempty : cover property (@(posedge clk) disable iff (!rst_n) almostempty);
   c_overflow    : cover property (@(posedge clk) disable iff (!rst_n) overflow);
   c_underflow   : cover property (@(posedge clk) disable iff (!rst_n) underflow);
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed table-driven bench for sync_fifo (FIFO_WIDTH=16, FIFO_DEPTH=8).
module tb_sync_fifo;

   logic        clk;
   logic        rst_n;
   logic [15:0] data_in;
   logic        wr_en;
   logic        rd_en;
   logic [15:0] data_out;
   logic        wr_ack;
   logic        overflow;
   logic        underflow;
   logic        full;
   logic        empty;
   logic        almostfull;
   logic        almostempty;

   int errors = 0;
   int checks = 0;

   sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_in     (data_in),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .data_out    (data_out),
      .wr_ack      (wr_ack),
      .overflow    (overflow),
      .underflow   (underflow),
      .full        (full),
      .empty       (empty),
      .almostfull  (almostfull),
      .almostempty (almostempty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [15:0] din;
      logic [15:0] dout;
      logic        ack;
      logic        ovf;
      logic        udf;
      logic        fl;
      logic        em;
      logic        af;
      logic        ae;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic wr, input logic rd, input logic [15:0] din,
                      input logic [15:0] dout, input logic ack, input logic ovf,
                      input logic udf, input logic fl, input logic em,
                      input logic af, input logic ae);
      vec_t v;
      v.wr = wr; v.rd = rd; v.din = din; v.dout = dout;
      v.ack = ack; v.ovf = ovf; v.udf = udf;
      v.fl = fl; v.em = em; v.af = af; v.ae = ae;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [step %0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic [15:0] dout, input logic ack,
                          input logic ovf, input logic udf, input logic fl,
                          input logic em, input logic af, input logic ae);
      chk("data_out",    idx, data_out,           dout);
      chk("wr_ack",      idx, 16'(wr_ack),        16'(ack));
      chk("overflow",    idx, 16'(overflow),      16'(ovf));
      chk("underflow",   idx, 16'(underflow),     16'(udf));
      chk("full",        idx, 16'(full),          16'(fl));
      chk("empty",       idx, 16'(empty),         16'(em));
      chk("almostfull",  idx, 16'(almostfull),    16'(af));
      chk("almostempty", idx, 16'(almostempty),   16'(ae));
   endtask

   // One clock: inputs already driven; sample 1 time unit after the edge.
   task automatic step(input logic wr, input logic rd, input logic [15:0] din);
      wr_en   = wr;
      rd_en   = rd;
      data_in = din;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      data_in = '0;

      // Fill 0001..0008, then a rejected write.
      for (int k = 1; k <= 8; k++)
         add(1, 0, 16'(k), 16'h0000, 1, 0, 0, k == 8, 0, k == 7, k == 1);
      add(1, 0, 16'hDEAD, 16'h0000, 0, 1, 0, 1, 0, 0, 0);
      // Drain in order, then an extra read that underflows and holds data.
      for (int k = 1; k <= 8; k++)
         add(0, 1, 16'h0000, 16'(k), 0, 0, 0, 0, k == 8, k == 1, k == 7);
      add(0, 1, 16'h0000, 16'h0008, 0, 0, 1, 0, 1, 0, 0);
      // Simultaneous on empty: write only, underflow flagged.
      add(1, 1, 16'hA5A5, 16'h0008, 1, 0, 1, 0, 0, 0, 1);
      // Refill to full with B001..B007 (count 2..8).
      for (int k = 1; k <= 7; k++)
         add(1, 0, 16'hB000 + 16'(k), 16'h0008, 1, 0, 0, k == 7, 0, k == 6, 0);
      // Simultaneous on full: read only, oldest word returned, overflow flagged.
      add(1, 1, 16'hDEAD, 16'hA5A5, 0, 1, 0, 0, 0, 1, 0);
      // Read down to count 4.
      for (int k = 1; k <= 3; k++)
         add(0, 1, 16'h0000, 16'hB000 + 16'(k), 0, 0, 0, 0, 0, 0, 0);
      // Ten cycles of simultaneous traffic at count 4, crossing pointer wrap.
      for (int i = 0; i < 10; i++)
         add(1, 1, 16'hC000 + 16'(i),
             (i < 4) ? 16'hB004 + 16'(i) : 16'hC000 + 16'(i - 4),
             1, 0, 0, 0, 0, 0, 0);
      // One more write to reach count 5.
      add(1, 0, 16'hC00A, 16'hC005, 1, 0, 0, 0, 0, 0, 0);

      // Reset held for two cycles, released between edges.
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_all(-1, 16'h0000, 0, 0, 0, 0, 1, 0, 0);

      foreach (vecs[i]) begin
         step(vecs[i].wr, vecs[i].rd, vecs[i].din);
         chk_all(i, vecs[i].dout, vecs[i].ack, vecs[i].ovf, vecs[i].udf,
                 vecs[i].fl, vecs[i].em, vecs[i].af, vecs[i].ae);
      end

      // Async reset mid-stream at count 5, asserted away from any edge.
      wr_en = 1'b0;
      rd_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all(100, 16'h0000, 0, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      // First cycle after reset behaves as empty: read underflows.
      step(0, 1, 16'h0000);
      chk_all(101, 16'h0000, 0, 0, 1, 0, 1, 0, 0);
      // Normal operation resumes: write then read back.
      step(1, 0, 16'h1234);
      chk_all(102, 16'h0000, 1, 0, 0, 0, 0, 0, 1);
      step(0, 1, 16'h0000);
      chk_all(103, 16'h1234, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 16'h0000);
      chk_all(104, 16'h1234, 0, 0, 0, 0, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1);
   end

endmodule
